alu_rs: RTL

- Reservation station plus single-cycle ALU for the out-of-order RV32I core.
- Accepts dispatched ALU/branch-compare ops from the Decoder and holds them until both operands are resolved.
- Operands are resolved by watching its own result bus and the LSB result bus.
- Issues one ready op per cycle and drives the rs_fi / rs_value / rs_rob_id writeback that the ROB consumes. It is the producer end of the ROB's RS result interface.

---
 rtl/alu_rs.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// alu_rs: reservation station plus single-cycle ALU for the out-of-order RV32I core.
// Holds dispatched ALU/branch-compare ops until both operands resolve from the
// own result bus or the LSB result bus, then issues one ready op per cycle.
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (pause), rob_clear (flush)
//   rs_full                       : no free entry (from registered count)
//   dis_*                         : dispatch interface from the Decoder
//   lsb_fi/lsb_value/lsb_rob_id   : LSB result broadcast
//   rs_fi/rs_value/rs_rob_id      : registered ALU result broadcast to the ROB
// Optional: define ALU_RS_OLDEST_FIRST_EN to select the oldest ready entry
// (wrap-aware dispatch sequence numbers) instead of the lowest index.
module alu_rs #(
  parameter int unsigned RS_SIZE_BIT  = 3,
  parameter int unsigned ROB_SIZE_BIT = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  output logic                    rs_full,
  input  logic                    dis_valid,
  input  logic [3:0]              dis_op,
  input  logic [31:0]             dis_vj,
  input  logic                    dis_qj_busy,
  input  logic [ROB_SIZE_BIT-1:0] dis_qj,
  input  logic [31:0]             dis_vk,
  input  logic                    dis_qk_busy,
  input  logic [ROB_SIZE_BIT-1:0] dis_qk,
  input  logic [ROB_SIZE_BIT-1:0] dis_rob_id,
  input  logic                    lsb_fi,
  input  logic [31:0]             lsb_value,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
  output logic                    rs_fi,
  output logic [31:0]             rs_value,
  output logic [ROB_SIZE_BIT-1:0] rs_rob_id
);

  localparam int unsigned N  = 1 << RS_SIZE_BIT;
  localparam int unsigned CW = RS_SIZE_BIT + 1;

  typedef struct packed {
    logic [3:0]              op;
    logic [31:0]             vj;
    logic                    qj_busy;
    logic [ROB_SIZE_BIT-1:0] qj;
    logic [31:0]             vk;
    logic                    qk_busy;
    logic [ROB_SIZE_BIT-1:0] qk;
    logic [ROB_SIZE_BIT-1:0] rob;
  } entry_t;

  logic [N-1:0]            valid_q, valid_d;
  entry_t                  ent_q [N];
  entry_t                  ent_d [N];
  logic [CW-1:0]           count_q, count_d;
  logic                    fi_q, fi_d;
  logic [31:0]             value_q, value_d;
  logic [ROB_SIZE_BIT-1:0] rob_q, rob_d;

`ifdef ALU_RS_OLDEST_FIRST_EN
  logic [CW-1:0] seq_q [N];
  logic [CW-1:0] seq_d [N];
  logic [CW-1:0] seq_ctr_q, seq_ctr_d;
  logic [CW-1:0] best_seq;
`endif

  logic [N-1:0]           ready;
  logic                   sel_vld;
  logic [RS_SIZE_BIT-1:0] sel_idx;
  logic [RS_SIZE_BIT-1:0] free_idx;
  logic [31:0]            alu_res;
  logic                   dis_fire;

  assign rs_full   = (count_q == CW'(N));
  assign rs_fi     = fi_q;
  assign rs_value  = value_q;
  assign rs_rob_id = rob_q;

  // Resolve a busy operand against both broadcast buses; returns {busy, value}.
  function automatic logic [32:0] resolve(
    input logic busy, input logic [ROB_SIZE_BIT-1:0] tag, input logic [31:0] val,
    input logic own_fi, input logic [ROB_SIZE_BIT-1:0] own_tag, input logic [31:0] own_val,
    input logic l_fi, input logic [ROB_SIZE_BIT-1:0] l_tag, input logic [31:0] l_val);
    logic [32:0] r;
    r = {busy, val};
    if (busy && own_fi && (tag == own_tag))    r = {1'b0, own_val};
    else if (busy && l_fi && (tag == l_tag))   r = {1'b0, l_val};
    return r;
  endfunction

  // Ready vector from registered state only.
  always_comb begin
    for (int i = 0; i < int'(N); i++)
      ready[i] = valid_q[i] & ~ent_q[i].qj_busy & ~ent_q[i].qk_busy;
  end

  // Issue select.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
    best_seq = '0;
    for (int i = 0; i < int'(N); i++) begin
      // a is older than b when (a - b) is negative in CW-bit wrap arithmetic
      if (ready[i] && (!sel_vld || ((CW'(seq_q[i] - best_seq) >> (CW - 1)) != '0))) begin
        sel_vld  = 1'b1;
        sel_idx  = RS_SIZE_BIT'(i);
        best_seq = seq_q[i];
      end
    end
`else
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_vld = 1'b1;
        sel_idx = RS_SIZE_BIT'(i);
      end
    end
`endif
  end

  // Lowest-index free slot for dispatch.
  always_comb begin
    free_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = RS_SIZE_BIT'(i);
  end

  // Single-cycle ALU on the selected entry.
  always_comb begin
    logic [31:0] a, b;
    a = ent_q[sel_idx].vj;
    b = ent_q[sel_idx].vk;
    unique case (ent_q[sel_idx].op)
      4'd0:    alu_res = a + b;
      4'd1:    alu_res = a - b;
      4'd2:    alu_res = a & b;
      4'd3:    alu_res = a | b;
      4'd4:    alu_res = a ^ b;
      4'd5:    alu_res = a << b[4:0];
      4'd6:    alu_res = a >> b[4:0];
      4'd7:    alu_res = 32'($signed(a) >>> b[4:0]);
      4'd8:    alu_res = {31'd0, $signed(a) < $signed(b)};
      4'd9:    alu_res = {31'd0, a < b};
      4'd10:   alu_res = {31'd0, a == b};
      4'd11:   alu_res = {31'd0, a != b};
      4'd12:   alu_res = {31'd0, $signed(a) < $signed(b)};
      4'd13:   alu_res = {31'd0, $signed(a) >= $signed(b)};
      4'd14:   alu_res = {31'd0, a < b};
      default: alu_res = {31'd0, a >= b};
    endcase
  end

  assign dis_fire = rdy_in && dis_valid && !rs_full && !rob_clear;

  // Next-state: flush, wakeup, issue, dispatch.
  always_comb begin
    logic [32:0] r;
    valid_d = valid_q;
    ent_d   = ent_q;
    count_d = count_q;
    fi_d    = fi_q;
    value_d = value_q;
    rob_d   = rob_q;
    r       = '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
    seq_d     = seq_q;
    seq_ctr_d = seq_ctr_q;
`endif
    if (rdy_in) begin
      if (rob_clear) begin
        valid_d = '0;
        count_d = '0;
        fi_d    = 1'b0;
      end else begin
        for (int i = 0; i < int'(N); i++) begin
          if (valid_q[i]) begin
            r = resolve(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj,
                        fi_q, rob_q, value_q, lsb_fi, lsb_rob_id, lsb_value);
            ent_d[i].qj_busy = r[32];
            ent_d[i].vj      = r[31:0];
            r = resolve(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk,
                        fi_q, rob_q, value_q, lsb_fi, lsb_rob_id, lsb_value);
            ent_d[i].qk_busy = r[32];
            ent_d[i].vk      = r[31:0];
          end
        end
        fi_d = sel_vld;
        if (sel_vld) begin
          valid_d[sel_idx] = 1'b0;
          value_d          = alu_res;
          rob_d            = ent_q[sel_idx].rob;
        end
        // Dispatch targets a slot free in registered state, never the issuing one.
        if (dis_fire) begin
          valid_d[free_idx]  = 1'b1;
          ent_d[free_idx].op  = dis_op;
          ent_d[free_idx].qj  = dis_qj;
          ent_d[free_idx].qk  = dis_qk;
          ent_d[free_idx].rob = dis_rob_id;
          r = resolve(dis_qj_busy, dis_qj, dis_vj,
                      fi_q, rob_q, value_q, lsb_fi, lsb_rob_id, lsb_value);
          ent_d[free_idx].qj_busy = r[32];
          ent_d[free_idx].vj      = r[31:0];
          r = resolve(dis_qk_busy, dis_qk, dis_vk,
                      fi_q, rob_q, value_q, lsb_fi, lsb_rob_id, lsb_value);
          ent_d[free_idx].qk_busy = r[32];
          ent_d[free_idx].vk      = r[31:0];
`ifdef ALU_RS_OLDEST_FIRST_EN
          seq_d[free_idx] = seq_ctr_q;
          seq_ctr_d       = seq_ctr_q + CW'(1);
`endif
        end
        count_d = count_q + CW'(dis_fire) - CW'(sel_vld);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
      count_q <= '0;
      fi_q    <= 1'b0;
      value_q <= '0;
      rob_q   <= '0;
      for (int i = 0; i < int'(N); i++) ent_q[i] <= '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
      seq_ctr_q <= '0;
      for (int i = 0; i < int'(N); i++) seq_q[i] <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      fi_q    <= fi_d;
      value_q <= value_d;
      rob_q   <= rob_d;
      for (int i = 0; i < int'(N); i++) ent_q[i] <= ent_d[i];
`ifdef ALU_RS_OLDEST_FIRST_EN
      seq_ctr_q <= seq_ctr_d;
      for (int i = 0; i < int'(N); i++) seq_q[i] <= seq_d[i];
`endif
    end
  end

endmodule
